// File: rtl/exp_coef_table_if.sv
// exp_coef_table_if
//   Bundles the coefficient-table ports: the reload write port, the lookup
//   request stream (valid/ready) and the result stream (valid/ready).
//   master : the datapath/loader side (drives writes, requests, out_ready)
//   slave  : the table itself
//   Ports carried:
//     wr_en, wr_addr, wr_data                  reload one entry per cycle
//     in_valid, in_ready, in_addr              lookup request stream
//     out_valid, out_ready                     lookup result stream
//     out_slope, out_intercept, out_perr       result payload
interface exp_coef_table_if #(
  parameter int ADDR_W = 7,
  parameter int HALF_W = 16
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [2*HALF_W-1:0]   wr_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [HALF_W-1:0]     out_slope;
  logic [HALF_W-1:0]     out_intercept;
  logic                  out_perr;

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_slope, out_intercept, out_perr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_slope, out_intercept, out_perr
  );
endinterface

// File: rtl/exp_coef_table.sv
// exp_coef_table
//   Runtime-loadable coefficient table for the piecewise-linear exponential
//   unit. Each entry is {slope, intercept}, HALF_W bits each. Lookups flow
//   through a two-stage pipeline:
//     S1 (_p1): requested segment index + valid
//     S2 (_p2): RAM read data + valid, drives the out_* ports
//   One global advance (adv = !out_valid || out_ready) moves both stages, so
//   a stalled consumer freezes the whole pipe and the request port.
//   Writes commit every cycle wr_en is high and are never stalled. A write to
//   the index being read in the same advancing cycle is forwarded into S2
//   (write-first).
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high; clears the valid bits only
//     bus    exp_coef_table_if.slave (write port, request and result streams)
//
//   Optional feature, macro EXP_LUT_PARITY_EN:
//     defined   - each entry carries even parity of both halves, checked in
//                 S2 and reported on out_perr together with out_valid
//     undefined - no parity bits stored, out_perr tied to 0
module exp_coef_table #(
  parameter int ADDR_W = 7,
  parameter int HALF_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  exp_coef_table_if.slave  bus
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int DATA_W = 2*HALF_W;
`ifdef EXP_LUT_PARITY_EN
  localparam int ENT_W  = DATA_W + 2;
`else
  localparam int ENT_W  = DATA_W;
`endif

`ifdef EXP_LUT_PARITY_EN
  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [HALF_W-1:0] h);
    return ^h;
  endfunction

  // {slope parity, intercept parity}
  function automatic logic [1:0] pair_par(input logic [DATA_W-1:0] d);
    return {even_par(d[DATA_W-1:HALF_W]), even_par(d[HALF_W-1:0])};
  endfunction
`endif

  // Entry as it is written into the RAM (or forwarded on a collision).
  function automatic logic [ENT_W-1:0] make_entry(input logic [DATA_W-1:0] d);
`ifdef EXP_LUT_PARITY_EN
    return {pair_par(d), d};
`else
    return d;
`endif
  endfunction

  logic [ENT_W-1:0]  mem [DEPTH];

  logic              adv;
  logic              rd_en;
  logic              fwd;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p2;
  logic [ENT_W-1:0]  ent_p2;

  assign adv   = !vld_p2 || bus.out_ready;
  // Read only when a real request moves into S2; a stall leaves S2 untouched.
  assign rd_en = adv && vld_p1;
  // Same-cycle write to the index being read: S2 takes the new value.
  assign fwd   = bus.wr_en && (bus.wr_addr == addr_p1);

  assign bus.in_ready = adv;

  // Write port: independent of the lookup pipe; ignored while in reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !reset)
      mem[bus.wr_addr] <= make_entry(bus.wr_data);
  end

  // ---- S1: request index ----
  always_ff @(posedge clk) begin
    if (reset)
      vld_p1 <= 1'b0;
    else if (adv)
      vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv)
      addr_p1 <= bus.in_addr;
  end

  // ---- S2: RAM read data ----
  always_ff @(posedge clk) begin
    if (reset)
      vld_p2 <= 1'b0;
    else if (adv)
      vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (rd_en)
      ent_p2 <= fwd ? make_entry(bus.wr_data) : mem[addr_p1];
  end

  assign bus.out_valid     = vld_p2;
  assign bus.out_slope     = ent_p2[DATA_W-1:HALF_W];
  assign bus.out_intercept = ent_p2[HALF_W-1:0];

`ifdef EXP_LUT_PARITY_EN
  assign bus.out_perr = vld_p2 && (pair_par(ent_p2[DATA_W-1:0]) != ent_p2[ENT_W-1:DATA_W]);
`else
  assign bus.out_perr = 1'b0;
`endif

endmodule
